gpr_file: RTL and testbench

- General-purpose register file for the 5-stage MIPS pipeline.
- Read side: the decode stage reads two operands, which become the EX-stage operand inputs (reg1/reg2).
- Write side: the write-back stage writes back results such as the EX logic result that has travelled down the pipeline.
- Two combinational read ports, one clocked write port, same-cycle write-to-read bypass, and a hardwired zero register.

---
 rtl/gpr_file.sv | 60 ++++++
 tb/tb_gpr_file.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// General-purpose register file: two combinational read ports, one clocked write port,
// same-cycle write-to-read bypass and a hardwired zero register.
module gpr_file #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    if (NUM_REGS != (1 << ADDR_W)) begin : gen_param_check
        $error("gpr_file: NUM_REGS must equal 2**ADDR_W");
    end

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Entry 0 is never written, so after reset it stays zero; reads also force it to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i[ADDR_W-1:0]] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs_q[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs_q[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed vectors with literal expectations plus a
// reference array model compared against both read ports every cycle.
module tb_gpr_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model [NR];

    gpr_file #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_REGS(NR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    // Architectural model: a plain array of register values.
    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) model[i] = '0;
        end else if (we && waddr != 0) begin
            model[waddr] = wdata;
        end
    end

    function automatic logic [DW-1:0] model_read(input logic re, input logic [AW-1:0] ra);
        if (rst || !re || ra == 0) return '0;
        if (we && waddr == ra) return wdata;
        return model[ra];
    endfunction

    always @(negedge clk) begin
        logic [DW-1:0] e1, e2;
        e1 = model_read(re1, raddr1);
        e2 = model_read(re2, raddr2);
        n_checks++;
        if (rdata1 !== e1) begin
            n_errors++;
            $display("FAIL model_port1 t=%0t raddr1=%0d got=%h exp=%h", $time, raddr1, rdata1, e1);
        end
        n_checks++;
        if (rdata2 !== e2) begin
            n_errors++;
            $display("FAIL model_port2 t=%0t raddr2=%0d got=%h exp=%h", $time, raddr2, rdata2, e2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic e1, input logic [AW-1:0] a1,
                         input logic e2, input logic [AW-1:0] a2);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    endtask

    task automatic expect_lit(input string name, input logic [DW-1:0] x1,
                              input logic [DW-1:0] x2);
        @(negedge clk);
        #1;
        n_checks++;
        if (rdata1 !== x1 || rdata2 !== x2) begin
            n_errors++;
            $display("FAIL %s got=%h/%h exp=%h/%h", name, rdata1, rdata2, x1, x2);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [AW-1:0] a;
        drive(1, 0, 0, 0, 1, 1, 1, 2);
        tick();
        tick();
        expect_lit("reset_outputs", 32'h0, 32'h0);
        tick();

        // Preload 1..31 with all ones.
        for (int i = 1; i < NR; i++) begin
            a = AW'(i);
            drive(0, 1, a, 32'hFFFF_FFFF, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 1, 5'd3, 1, 5'd31);
        expect_lit("preload", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < NR; i++) begin
            a = AW'(i);
            drive(0, 0, 0, 0, 1, a, 1, ~a);
            expect_lit("reset_clear", 32'h0, 32'h0);
            tick();
        end

        // Basic write then read.
        drive(0, 1, 5'd5, 32'h1234_5678, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 5'd5, 1, 5'd5);
        expect_lit("basic_read", 32'h1234_5678, 32'h1234_5678);
        tick();
        drive(0, 0, 0, 0, 0, 5'd5, 1, 5'd5);
        expect_lit("basic_re_off", 32'h0, 32'h1234_5678);
        tick();

        // Zero register.
        drive(0, 1, 5'd0, 32'hDEAD_BEEF, 1, 5'd0, 1, 5'd0);
        expect_lit("zero_same_cycle", 32'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 5'd0, 1, 5'd0);
        expect_lit("zero_next_cycle", 32'h0, 32'h0);
        tick();

        // Bypass with and without we.
        drive(0, 1, 5'd7, 32'h1, 0, 0, 0, 0);
        tick();
        drive(0, 1, 5'd7, 32'hA5A5_A5A5, 1, 5'd7, 1, 5'd7);
        expect_lit("bypass_both", 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        tick();
        drive(0, 1, 5'd7, 32'h1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 5'd7, 32'hA5A5_A5A5, 1, 5'd7, 1, 5'd7);
        expect_lit("no_bypass_we0", 32'h1, 32'h1);
        tick();
        drive(0, 1, 5'd5, 32'hCAFE_0001, 1, 5'd5, 1, 5'd7);
        expect_lit("bypass_one_port", 32'hCAFE_0001, 32'h1);
        tick();

        // Reset during a write: reset wins and bypass is suppressed.
        drive(0, 1, 5'd9, 32'h77, 0, 0, 0, 0);
        tick();
        drive(1, 1, 5'd9, 32'h55, 1, 5'd9, 1, 5'd9);
        expect_lit("reset_mid_write", 32'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 5'd9, 1, 5'd7);
        expect_lit("after_reset_write", 32'h0, 32'h0);
        tick();

        // Random stress; narrow address range half the time to force collisions.
        for (int c = 0; c < 10000; c++) begin
            r = $urandom;
            rst = ($urandom_range(0, 63) == 0);
            we = r[0] | r[1];
            re1 = r[2] | r[3] | r[4];
            re2 = r[5] | r[6] | r[7];
            wdata = $urandom;
            r = $urandom;
            if (r[31]) begin
                waddr = {2'b00, r[2:0]};
                raddr1 = {2'b00, r[5:3]};
                raddr2 = {2'b00, r[8:6]};
            end else begin
                waddr = r[4:0];
                raddr1 = r[9:5];
                raddr2 = r[30] ? r[9:5] : r[14:10];
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
